huff_bitpack_enc: RTL and testbench

Huffman bit packer for the JPEG encode path, the transmit-side counterpart of the Huffman token decoder. It accepts variable-length code tokens (code bits plus length), packs them MSB-first into a byte stream, and inserts a 0x00 stuff byte after every 0xFF. At end of stream it pads the last partial byte with 1s and forwards the end-of-stream token. All streams use the page stream protocol: `_d` data, `_e` end-of-stream, `_v` valid, `_b` back-pressure.

---
 rtl/huff_bitpack_enc_pkg.sv | 37 +++
 rtl/huff_bitpack_enc_if.sv | 18 +
 rtl/huff_bitpack_enc_outreg.sv | 45 ++++
 rtl/huff_bitpack_enc.sv | 150 +++++++++++++++
 tb/tb_huff_bitpack_enc.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/huff_bitpack_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : huff_pkg
// Brief    : Shared types, constants and token helpers for the Huffman packer.
// Revision : 1.0
// ============================================================================
package huff_pkg;

    localparam int TOKEN_W = 21;
    localparam int LEN_W   = 5;
    localparam int ACC_W   = 32;
    localparam int MAX_LEN = 16;

    localparam logic [7:0] BYTE_FF    = 8'hFF;
    localparam logic [7:0] STUFF_BYTE = 8'h00;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STUFF   = 2'd1,
        PAD     = 2'd2,
        EOS_OUT = 2'd3
    } enc_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

    // len is expected to be clamped already, so the mask never exceeds 16 bits
    function automatic logic [MAX_LEN-1:0] mask_code(input logic [LEN_W-1:0] len,
                                                     input logic [MAX_LEN-1:0] code);
        logic [MAX_LEN:0] m;
        m = ((MAX_LEN+1)'(1) << len) - (MAX_LEN+1)'(1);
        return code & m[MAX_LEN-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/huff_bitpack_enc_if.sv
`default_nettype none
// ============================================================================
// Module   : huff_bitpack_enc_if
// Brief    : Page stream bundle: data, end-of-stream, valid, back-pressure.
// Revision : 1.0
// ============================================================================
interface huff_bitpack_enc_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] d;
    logic              e;
    logic              v;
    logic              b;

    modport master (output d, output e, output v, input  b);
    modport slave  (input  d, input  e, input  v, output b);
endinterface
`default_nettype wire

// File: rtl/huff_bitpack_enc_outreg.sv
`default_nettype none
// ============================================================================
// Module   : stream_outreg
// Brief    : One-entry registered page-stream output stage (d/e/v/b).
// Revision : 1.0
// ============================================================================
module stream_outreg #(
    parameter int DATA_W = 8
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              i_load_v,
    input  wire logic [DATA_W-1:0] i_load_d,
    input  wire logic              i_load_e,
    output      logic              o_free,
    huff_bitpack_enc_if.master     o_dst
);

    logic [DATA_W-1:0] r_d;
    logic              r_e;
    logic              r_v;

    // Free when empty or when the held entry leaves on this edge
    assign o_free = !r_v || !o_dst.b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_d <= '0;
            r_e <= 1'b0;
            r_v <= 1'b0;
        end else if (o_free) begin
            r_v <= i_load_v;
            if (i_load_v) begin
                r_d <= i_load_d;
                r_e <= i_load_e;
            end
        end
    end

    assign o_dst.d = r_d;
    assign o_dst.e = r_e;
    assign o_dst.v = r_v;

endmodule
`default_nettype wire

// File: rtl/huff_bitpack_enc.sv
`default_nettype none
// ============================================================================
// Module   : huff_bitpack_enc
// Brief    : Packs Huffman code tokens MSB-first into bytes with 0xFF stuffing.
// Revision : 1.0
// ============================================================================
module huff_bitpack_enc #(
    parameter int TOKEN_W = 21,
    parameter int ACC_W   = 32
) (
    input  wire logic          clock,
    input  wire logic          reset,
    huff_bitpack_enc_if.slave  token,
    huff_bitpack_enc_if.master filebyte
);
    import huff_pkg::*;

    localparam int CNT_W = $clog2(ACC_W + 1);

    enc_state_t         r_state, w_state_nxt;
    logic               r_ret_pad, w_ret_pad_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt, w_acc_sh;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_sh;
    logic               w_free, w_load_v, w_load_e, w_token_b, w_accept;
    logic [7:0]         w_load_d, w_top, w_pad_byte;
    logic [LEN_W-1:0]   w_len;
    logic [MAX_LEN-1:0] w_code;
    logic [CNT_W:0]     w_shamt;

    assign w_token_b = !reset || (r_state != RUN) || (r_cnt > CNT_W'(MAX_LEN));
    assign token.b   = w_token_b;
    assign w_accept  = token.v && !w_token_b;

    assign w_len      = clamp_len(token.d[TOKEN_W-1 -: LEN_W]);
    assign w_code     = mask_code(w_len, token.d[MAX_LEN-1:0]);
    assign w_top      = r_acc[ACC_W-1 -: 8];
    assign w_pad_byte = w_top | (8'hFF >> r_cnt);

    always_comb begin
        w_state_nxt   = r_state;
        w_ret_pad_nxt = r_ret_pad;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_acc_sh      = r_acc;
        w_cnt_sh      = r_cnt;
        w_load_v      = 1'b0;
        w_load_d      = STUFF_BYTE;
        w_load_e      = 1'b0;
        w_shamt       = '0;

        case (r_state)
            RUN: begin
                if (r_cnt >= CNT_W'(8) && w_free) begin
                    w_load_v = 1'b1;
                    w_load_d = w_top;
                    w_acc_sh = r_acc << 8;
                    w_cnt_sh = r_cnt - CNT_W'(8);
                    if (w_top == BYTE_FF) begin
                        w_state_nxt   = STUFF;
                        w_ret_pad_nxt = 1'b0;
                    end
                end
                w_acc_nxt = w_acc_sh;
                w_cnt_nxt = w_cnt_sh;
                if (w_accept) begin
                    if (token.e) begin
                        // A stuff byte owed this cycle is sent before padding starts
                        if (w_state_nxt == STUFF) w_ret_pad_nxt = 1'b1;
                        else                      w_state_nxt   = PAD;
                    end else begin
                        w_shamt   = (CNT_W+1)'(ACC_W) - {1'b0, w_cnt_sh}
                                  - (CNT_W+1)'(w_len);
                        w_acc_nxt = w_acc_sh | (ACC_W'(w_code) << w_shamt);
                        w_cnt_nxt = w_cnt_sh + CNT_W'(w_len);
                    end
                end
            end
            STUFF: begin
                if (w_free) begin
                    w_load_v    = 1'b1;
                    w_load_d    = STUFF_BYTE;
                    w_state_nxt = r_ret_pad ? PAD : RUN;
                end
            end
            PAD: begin
                if (r_cnt >= CNT_W'(8)) begin
                    if (w_free) begin
                        w_load_v  = 1'b1;
                        w_load_d  = w_top;
                        w_acc_nxt = r_acc << 8;
                        w_cnt_nxt = r_cnt - CNT_W'(8);
                    end
                end else if (r_cnt != '0) begin
                    if (w_free) begin
                        w_load_v  = 1'b1;
                        w_load_d  = w_pad_byte;
                        w_acc_nxt = '0;
                        w_cnt_nxt = '0;
                    end
                end else begin
                    w_state_nxt = EOS_OUT;
                end
                if (w_load_v && w_load_d == BYTE_FF) begin
                    w_state_nxt   = STUFF;
                    w_ret_pad_nxt = 1'b1;
                end
            end
            EOS_OUT: begin
                if (w_free) begin
                    w_load_v      = 1'b1;
                    w_load_d      = STUFF_BYTE;
                    w_load_e      = 1'b1;
                    w_acc_nxt     = '0;
                    w_cnt_nxt     = '0;
                    w_ret_pad_nxt = 1'b0;
                    w_state_nxt   = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= RUN;
            r_ret_pad <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret_pad <= w_ret_pad_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    stream_outreg #(
        .DATA_W (8)
    ) u_outreg (
        .clock    (clock),
        .reset    (reset),
        .i_load_v (w_load_v),
        .i_load_d (w_load_d),
        .i_load_e (w_load_e),
        .o_free   (w_free),
        .o_dst    (filebyte)
    );

endmodule
`default_nettype wire

// File: tb/tb_huff_bitpack_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_huff_bitpack_enc
// Brief    : Directed and random checks of the packer against a bit-queue model.
// Revision : 1.0
// ============================================================================
module tb_huff_bitpack_enc;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    huff_bitpack_enc_if #(.DATA_W(21)) tok_if ();
    huff_bitpack_enc_if #(.DATA_W(8))  fb_if  ();

    huff_bitpack_enc dut (
        .clock    (clock),
        .reset    (reset),
        .token    (tok_if),
        .filebyte (fb_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    bit         bq[$];
    logic [8:0] expq[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_ed = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the output is the concatenated code bits cut into bytes,
    // each 0xFF followed by 0x00, the tail padded with ones, then an EOS beat.
    task automatic flush_bytes();
        logic [7:0] by;
        while (bq.size() >= 8) begin
            for (int i = 0; i < 8; i++) by = {by[6:0], bq.pop_front()};
            expq.push_back({1'b0, by});
            if (by == 8'hFF) expq.push_back(9'h000);
        end
    endtask

    task automatic model_token(input logic [20:0] d, input logic e);
        int len;
        if (e) begin
            if (bq.size() > 0) while (bq.size() < 8) bq.push_back(1'b1);
            flush_bytes();
            expq.push_back(9'h100);
        end else begin
            len = int'(d[20:16]);
            if (len > 16) len = 16;
            for (int i = len - 1; i >= 0; i--) bq.push_back(d[i]);
            flush_bytes();
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            bq.delete();
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check_val("stall_hold", {fb_if.v, fb_if.e, fb_if.d}, {1'b1, prev_ed});
            if (tok_if.v && !tok_if.b) model_token(tok_if.d, tok_if.e);
            if (fb_if.v && !fb_if.b) begin
                check_val("out_avail", 32'(expq.size() != 0), 1);
                if (expq.size() != 0) check_val("out_beat", {fb_if.e, fb_if.d}, expq.pop_front());
            end
            prev_stall = fb_if.v && fb_if.b;
            prev_ed    = {fb_if.e, fb_if.d};
        end
    end

    task automatic send(input logic [4:0] len, input logic [15:0] code, input logic eos);
        logic ok;
        ok = 1'b0;
        tok_if.d = {len, code};
        tok_if.e = eos;
        tok_if.v = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (!tok_if.b) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("tok_accept", 32'(ok), 1);
        @(posedge clock);
        #1;
        tok_if.v = 1'b0;
        tok_if.e = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(posedge clock);
            #2;
            if (expq.size() == 0 && !fb_if.v) break;
        end
        repeat (4) @(posedge clock);
        #2;
        check_val("drain_left", expq.size(), 0);
    endtask

    logic       saw_tb;
    logic [4:0] rl;

    initial begin
        tok_if.d = '0;
        tok_if.e = 1'b0;
        tok_if.v = 1'b0;
        fb_if.b  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_v", fb_if.v, 0);
        check_val("rst_tb", tok_if.b, 1);
        reset = 1'b1;
        @(negedge clock);
        check_val("rel_tb", tok_if.b, 0);

        // Reset mid-stream: output register holds 0x12 and a partial byte is pending
        send(5'd8, 16'h0012, 1'b0);
        send(5'd3, 16'h0005, 1'b0);
        check_val("pre_rst_v", fb_if.v, 1);
        reset = 1'b0;
        #2;
        check_val("mid_rst_v", fb_if.v, 0);
        check_val("mid_rst_e", fb_if.e, 0);
        check_val("mid_rst_d", fb_if.d, 0);
        check_val("mid_rst_tb", tok_if.b, 1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_val("rel2_tb", tok_if.b, 0);
        @(posedge clock);
        #1;

        // Packing and latency
        send(5'd4, 16'h000A, 1'b0);
        send(5'd4, 16'h0005, 1'b0);
        check_val("lat_v0", fb_if.v, 0);
        @(posedge clock);
        #1;
        check_val("lat_v1", fb_if.v, 1);
        check_val("lat_d", fb_if.d, 8'hA5);
        send(5'd8, 16'h003C, 1'b0);
        drain();

        // Stuffing, padding, restart
        send(5'd8, 16'h00FF, 1'b0);
        send(5'd8, 16'h0012, 1'b0);
        send(5'd3, 16'h0005, 1'b0);
        send(5'd0, 16'h0000, 1'b1);
        send(5'd1, 16'h0001, 1'b0);
        send(5'd0, 16'h0000, 1'b1);
        send(5'd8, 16'h0055, 1'b0);
        send(5'd0, 16'h0000, 1'b1);
        drain();

        // Back-pressure
        saw_tb = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(5'd16, 16'hABCD, 1'b0);
            end
            begin
                fb_if.b = 1'b1;
                repeat (6) begin
                    @(negedge clock);
                    if (tok_if.b) saw_tb = 1'b1;
                end
                @(posedge clock);
                #1;
                fb_if.b = 1'b0;
            end
        join
        check_val("bp_token_b", 32'(saw_tb), 1);
        send(5'd0, 16'h0000, 1'b1);
        drain();

        // Length edges
        send(5'd0, 16'hFFFF, 1'b0);
        send(5'd20, 16'h1234, 1'b0);
        send(5'd5, 16'hFFE3, 1'b0);
        send(5'd0, 16'h0000, 1'b1);
        drain();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            rl       = 5'($urandom_range(0, 20));
            tok_if.d = {rl, 16'($urandom)};
            tok_if.e = ($urandom_range(0, 39) == 0);
            tok_if.v = ($urandom_range(0, 2) != 0);
            fb_if.b  = ($urandom_range(0, 3) == 0);
        end
        @(posedge clock);
        #1;
        tok_if.v = 1'b0;
        tok_if.e = 1'b0;
        fb_if.b  = 1'b0;
        send(5'd0, 16'h0000, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
